// File: rtl/sobel_edge_stream.sv
// Sobel gradient-magnitude filter over a raster-order 8-bit grayscale stream.
// Two line buffers feed a 3x3 window; |Gx|+|Gy| is computed in a 2-stage
// pipeline and saturated to 8 bits. Only interior pixels produce results.
module sobel_edge_stream #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_BITS   = $clog2(IMG_WIDTH),
  parameter int ROW_BITS   = $clog2(IMG_HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sof,
  input  logic                in_valid,
  input  logic [7:0]          in_pixel,
  output logic                out_valid,
  output logic [7:0]          out_pixel,
  output logic [ROW_BITS-1:0] out_row,
  output logic [COL_BITS-1:0] out_col,
  output logic                frame_done,
  output logic                err
);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);

  // frame position / protocol state
  logic                active_q, active_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                err_q, err_d;
  logic                accept;
  logic [ROW_BITS-1:0] acc_row;
  logic [COL_BITS-1:0] acc_col;

  // line buffers: lb0 holds row r-1, lb1 holds row r-2 (not reset)
  logic [7:0] lb0_q [IMG_WIDTH];
  logic [7:0] lb1_q [IMG_WIDTH];

  // stage 0: window + tag; stage 1: abs gradients; stage 2: outputs
  logic [2:0]            vld_pipe_q, vld_pipe_d;
  logic [2:0][2:0][7:0]  win_q, win_d;
  logic [ROW_BITS-1:0]   tag0_row_q, tag0_row_d, tag1_row_q, tag1_row_d;
  logic [COL_BITS-1:0]   tag0_col_q, tag0_col_d, tag1_col_q, tag1_col_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [9:0]            gx_abs_q, gx_abs_d, gy_abs_q, gy_abs_d;
  logic [7:0]            out_pixel_q, out_pixel_d;
  logic [ROW_BITS-1:0]   out_row_q, out_row_d;
  logic [COL_BITS-1:0]   out_col_q, out_col_d;
  logic                  frame_done_q, frame_done_d;
  logic signed [10:0]    gx, gy;
  logic [10:0]           mag;

  function automatic logic signed [10:0] ext(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  // frame control: a sof pixel always restarts at (0,0); stray pixels in IDLE are dropped
  always_comb begin
    accept   = in_valid && (sof || active_q);
    acc_row  = sof ? '0 : row_q;
    acc_col  = sof ? '0 : col_q;
    err_d    = in_valid && (sof == active_q);
    active_d = active_q;
    row_d    = row_q;
    col_d    = col_q;
    if (accept) begin
      active_d = 1'b1;
      row_d    = acc_row;
      if (acc_col == LAST_COL) begin
        col_d = '0;
        if (acc_row == LAST_ROW) begin
          row_d    = '0;
          active_d = 1'b0;
        end else begin
          row_d = acc_row + ROW_BITS'(1);
        end
      end else begin
        col_d = acc_col + COL_BITS'(1);
      end
    end
  end

  // window shift and stage-0 tagging; window edges at c<2 straddle rows and stay invalid
  always_comb begin
    win_d      = win_q;
    tag0_row_d = tag0_row_q;
    tag0_col_d = tag0_col_q;
    last0_d    = last0_q;
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_q[acc_col];
      win_d[1][2] = lb0_q[acc_col];
      win_d[2][2] = in_pixel;
      tag0_row_d  = acc_row - ROW_BITS'(1);
      tag0_col_d  = acc_col - COL_BITS'(1);
      last0_d     = (acc_row == LAST_ROW) && (acc_col == LAST_COL);
    end
    vld_pipe_d[0] = accept && (acc_row >= ROW_BITS'(2)) && (acc_col >= COL_BITS'(2));
  end

  // stage 1: Sobel kernels and absolute values
  always_comb begin
    gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
    gx_abs_d      = gx[10] ? 10'(-gx) : 10'(gx);
    gy_abs_d      = gy[10] ? 10'(-gy) : 10'(gy);
    tag1_row_d    = tag0_row_q;
    tag1_col_d    = tag0_col_q;
    last1_d       = last0_q;
    vld_pipe_d[1] = vld_pipe_q[0];
  end

  // stage 2: saturating sum; result fields hold between pulses
  always_comb begin
    mag           = {1'b0, gx_abs_q} + {1'b0, gy_abs_q};
    out_pixel_d   = out_pixel_q;
    out_row_d     = out_row_q;
    out_col_d     = out_col_q;
    frame_done_d  = 1'b0;
    vld_pipe_d[2] = vld_pipe_q[1];
    if (vld_pipe_q[1]) begin
      out_pixel_d  = (mag > 11'd255) ? 8'hFF : mag[7:0];
      out_row_d    = tag1_row_q;
      out_col_d    = tag1_col_q;
      frame_done_d = last1_q;
    end
  end

  // line buffer RAM writes
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[acc_col] <= lb0_q[acc_col];
      lb0_q[acc_col] <= in_pixel;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      err_q        <= 1'b0;
      vld_pipe_q   <= '0;
      win_q        <= '0;
      tag0_row_q   <= '0;
      tag0_col_q   <= '0;
      last0_q      <= 1'b0;
      tag1_row_q   <= '0;
      tag1_col_q   <= '0;
      last1_q      <= 1'b0;
      gx_abs_q     <= '0;
      gy_abs_q     <= '0;
      out_pixel_q  <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      row_q        <= row_d;
      col_q        <= col_d;
      err_q        <= err_d;
      vld_pipe_q   <= vld_pipe_d;
      win_q        <= win_d;
      tag0_row_q   <= tag0_row_d;
      tag0_col_q   <= tag0_col_d;
      last0_q      <= last0_d;
      tag1_row_q   <= tag1_row_d;
      tag1_col_q   <= tag1_col_d;
      last1_q      <= last1_d;
      gx_abs_q     <= gx_abs_d;
      gy_abs_q     <= gy_abs_d;
      out_pixel_q  <= out_pixel_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = vld_pipe_q[2];
  assign out_pixel  = out_pixel_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench for sobel_edge_stream on an 8x6 image.
module tb_sobel_edge_stream;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic       out_valid, frame_done, err;
  logic [7:0] out_pixel;
  logic [2:0] out_row;
  logic [2:0] out_col;

  sobel_edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .sof(sof), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int row;
    int col;
    int last;
    int due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int img [H][W];
  int n_chk = 0, n_fail = 0;
  int ncnt = 0, err_cnt = 0, vld_cnt = 0, done_cnt = 0, sat_cnt = 0, nz_cnt = 0;
  int last_pix = 0, last_row = 0, last_col = 0;
  int v0, d0, e0, s0, z0;

  // reference Sobel magnitude centred on (r,c) of the current image
  function automatic int ref_mag(input int r, input int c);
    int gx, gy, m;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // output monitor: pops the scoreboard on every result, checks hold otherwise
  always @(negedge clk) begin
    ncnt++;
    if (!reset) begin
      if (err) err_cnt++;
      if (out_valid) begin
        vld_cnt++;
        if (frame_done) done_cnt++;
        if (out_pixel == 8'd255) sat_cnt++;
        if (out_pixel != 8'd0) nz_cnt++;
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got pix=%0d row=%0d col=%0d, expected none",
                   out_pixel, out_row, out_col);
        end else begin
          e = sbq.pop_front();
          if ({out_pixel, out_row, out_col, frame_done} !==
              {8'(e.pix), 3'(e.row), 3'(e.col), (e.last != 0)}) begin
            n_fail++;
            $display("FAIL result_data: got pix=%0d row=%0d col=%0d done=%0d, expected pix=%0d row=%0d col=%0d done=%0d",
                     out_pixel, out_row, out_col, frame_done, e.pix, e.row, e.col, e.last);
          end
          n_chk++;
          if (ncnt !== e.due) begin
            n_fail++;
            $display("FAIL result_latency: (%0d,%0d) at sample %0d, expected %0d",
                     e.row, e.col, ncnt, e.due);
          end
        end
        last_pix = out_pixel;
        last_row = out_row;
        last_col = out_col;
      end else begin
        n_chk++;
        if ({out_pixel, out_row, out_col, frame_done} !==
            {8'(last_pix), 3'(last_row), 3'(last_col), 1'b0}) begin
          n_fail++;
          $display("FAIL output_hold: got pix=%0d row=%0d col=%0d done=%0d, expected pix=%0d row=%0d col=%0d done=0",
                   out_pixel, out_row, out_col, frame_done, last_pix, last_row, last_col);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int r, input int c, input bit s);
    in_valid = 1'b1;
    sof      = s;
    in_pixel = 8'(img[r][c]);
    tick();
    if (r >= 2 && c >= 2)
      sbq.push_back('{ref_mag(r-1, c-1), r-1, c-1, int'(r == H-1 && c == W-1), ncnt + 3});
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic drive_frame(input int npix, input int gap_max);
    for (int k = 0; k < npix; k++) begin
      drive_pix(k / W, k % W, k == 0);
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
    end
  endtask

  task automatic fill_flat(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_step();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 255 : 0;
  endtask

  task automatic snap();
    v0 = vld_cnt; d0 = done_cnt; e0 = err_cnt; s0 = sat_cnt; z0 = nz_cnt;
  endtask

  // drains the pipeline, then checks per-test counts and an empty scoreboard
  task automatic finish_check(input string nm, input int nv, input int nd, input int ne,
                              input int ns, input int nz);
    repeat (6) tick();
    n_chk++;
    if (vld_cnt - v0 !== nv) begin
      n_fail++; $display("FAIL %s_count: got %0d results, expected %0d", nm, vld_cnt - v0, nv);
    end
    n_chk++;
    if (done_cnt - d0 !== nd) begin
      n_fail++; $display("FAIL %s_frame_done: got %0d, expected %0d", nm, done_cnt - d0, nd);
    end
    n_chk++;
    if (err_cnt - e0 !== ne) begin
      n_fail++; $display("FAIL %s_err: got %0d pulses, expected %0d", nm, err_cnt - e0, ne);
    end
    if (ns >= 0) begin
      n_chk++;
      if (sat_cnt - s0 !== ns) begin
        n_fail++; $display("FAIL %s_saturated: got %0d, expected %0d", nm, sat_cnt - s0, ns);
      end
    end
    if (nz >= 0) begin
      n_chk++;
      if (nz_cnt - z0 !== nz) begin
        n_fail++; $display("FAIL %s_nonzero: got %0d, expected %0d", nm, nz_cnt - z0, nz);
      end
    end
    n_chk++;
    if (sbq.size() !== 0) begin
      n_fail++; $display("FAIL %s_pending: %0d results never produced, expected 0", nm, sbq.size());
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    n_chk++;
    if ({out_valid, out_pixel, out_row, out_col, frame_done, err} !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: got valid=%0d pix=%0d row=%0d col=%0d done=%0d err=%0d, expected all 0",
               nm, out_valid, out_pixel, out_row, out_col, frame_done, err);
    end
  endtask

  task automatic test_reset();
    #1;
    check_zero_outputs("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
  endtask

  task automatic test_flat();
    fill_flat(100); snap();
    drive_frame(W*H, 0);
    finish_check("flat", 24, 1, 0, 0, 0);
  endtask

  task automatic test_vstep();
    fill_step(); snap();
    drive_frame(W*H, 0);
    finish_check("vstep", 24, 1, 0, 8, 8);
  endtask

  task automatic test_impulse();
    fill_flat(0); img[3][3] = 10; snap();
    drive_frame(W*H, 0);
    finish_check("impulse", 24, 1, 0, 0, 8);
  endtask

  task automatic test_idle_gaps();
    fill_step(); snap();
    drive_frame(W*H, 3);
    finish_check("gaps", 24, 1, 0, 8, 8);
  endtask

  task automatic test_sof_restart();
    fill_step(); snap();
    drive_frame(3*W + 5, 0);   // frame 1 stops after (3,4); next pixel is a new sof
    fill_flat(100);
    drive_frame(W*H, 0);
    finish_check("restart", 9 + 24, 1, 1, -1, -1);
  endtask

  task automatic test_reset_mid();
    fill_step();
    drive_frame(3*W + 6, 0);
    #2 reset = 1'b1;
    #1;
    check_zero_outputs("reset_mid");
    sbq.delete();
    last_pix = 0; last_row = 0; last_col = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
  endtask

  task automatic test_protocol();
    snap();
    img[0][0] = 77;
    in_valid = 1'b1; sof = 1'b0; in_pixel = 8'd77;
    tick();
    in_valid = 1'b0;
    finish_check("no_sof", 0, 0, 1, -1, -1);
  endtask

  task automatic test_after_reset();
    fill_flat(100); snap();
    drive_frame(W*H, 0);
    finish_check("post_reset", 24, 1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vstep();
    test_impulse();
    test_idle_gaps();
    test_sof_restart();
    test_reset_mid();
    test_protocol();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Downstream consumer of the image-processing pixel stream: takes raster-order 8-bit grayscale pixels and emits a Sobel gradient-magnitude stream.
- The magnitude stream is what is written back out as the filtered SD-card image.
- Internally it holds two line buffers and a 3x3 window, and feeds a 2-stage arithmetic pipeline.
- Only interior pixels are produced: (W-2)x(H-2) results per frame.

Parameters:
- IMG_WIDTH, 640: pixels per row (W), minimum 3.
- IMG_HEIGHT, 480: rows per frame (H), minimum 3.
- COL_BITS, $clog2(IMG_WIDTH): width of column counter and out_col.
- ROW_BITS, $clog2(IMG_HEIGHT): width of row counter and out_row.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sof  input  1  start of frame; qualified by in_valid; marks pixel (0,0).
- in_valid  input  1  in_pixel valid this cycle; no backpressure, block always accepts.
- in_pixel  input  8  grayscale pixel, unsigned.
- out_valid  output  1  one-cycle pulse per result.
- out_pixel  output  8  saturated |Gx|+|Gy|.
- out_row  output  ROW_BITS  row of result's centre pixel, 1..H-2.
- out_col  output  COL_BITS  column of result's centre pixel, 1..W-2.
- frame_done  output  1  pulses with out_valid of the final result (H-2,W-2).
- err  output  1  one-cycle protocol error pulse.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: all outputs 0; row/col counters 0; frame_active=0; window and pipeline valid bits cleared. Line-buffer RAM is not reset; rows 0-1 are always written before they are read.
- Frame state: IDLE (frame_active=0) and ACTIVE.
  - IDLE: in_valid&sof accepts the pixel as (0,0) and enters ACTIVE. in_valid&!sof drops the pixel and pulses err.
  - ACTIVE: each in_valid advances col. At col=W-1, col wraps to 0 and row increments. Accepting (H-1,W-1) returns the block to IDLE.
  - ACTIVE with in_valid&sof: the current frame is abandoned, err pulses, and the pixel is accepted as (0,0) of a new frame. The abandoned frame never produces frame_done. Results already in the pipeline drain normally.
  - sof without in_valid is ignored.
- Accept edge N (pixel at row r, col c):
  - The 3x3 window shifts left by one column.
  - The new right column is {lb1[c] (row r-2), lb0[c] (row r-1), in_pixel (row r)}.
  - lb1[c]<=lb0[c] and lb0[c]<=in_pixel.
- Window notation: p[i][j], where i=0 is the top row and j=0 is the left column.
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Both are signed 11-bit, range ±1020.
- Pipeline:
  - Edge N+1 registers |Gx| and |Gy| as 10-bit unsigned values.
  - Edge N+2 registers the 11-bit sum, saturated to 255 when the sum exceeds 255, into out_pixel.
  - Result valid iff r>=2 and c>=2. It is tagged out_row=r-1, out_col=c-1.
  - out_valid is high for exactly the one cycle following edge N+2; latency is 2 edges after acceptance.
- Idle cycles: gaps in in_valid freeze the window and counters. Pipeline valid bits advance each cycle, so each result is emitted exactly once.
- Output hold: out_pixel, out_row and out_col hold their last value while out_valid=0.
- Row wrap: the window contents at c=0 and c=1 span the row boundary and are never emitted, so no flushing is required.
- Reset mid-operation takes effect immediately (asynchronous). Outputs drop to 0 in the same cycle and in-flight results are discarded.
- Throughput: one pixel per clock sustained.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6):
- Flat frame: every pixel=100 -> 24 out_valid pulses, all out_pixel=0. out_row/out_col walk (1,1)..(4,6). frame_done coincides with (4,6) only.
- Vertical step: cols 0-3=0, cols 4-7=255 -> out_col 3 and 4 give Gx=1020, saturating to 255. All other columns give 0. Each result appears 2 edges after its accepting pixel.
- Impulse: pixel (3,3)=10, all others 0 -> centre (2,2)=20, (3,2)=20, (4,4)=20, (3,3)=0. Remaining neighbours match the hand-computed kernel.
- Idle gaps: repeat the vertical-step frame with random 0-3 idle cycles between pixels -> identical result sequence, 24 results, one frame_done.
- sof restart: sof at pixel (3,5) of frame 1, then a full flat frame -> one err pulse and no frame_done for frame 1. Frame 2 yields 24 zero results and one frame_done.
- Protocol/reset:
  - in_valid without sof after reset -> err pulse and no output.
  - reset asserted mid-frame between edges -> all outputs 0 immediately.
  - New sof frame afterwards processes correctly.
